// File: rtl/sgf_align_unit_if.sv
// Handshake bundle for the operand-alignment stage.
// The op_* side carries operand pairs in; the res_* side carries aligned results out.
interface sgf_align_unit_if #(
  parameter int SWR = 26,
  parameter int EW  = 8
);
  logic           op_valid;
  logic           op_ready;
  logic [EW-1:0]  exp_a;
  logic [EW-1:0]  exp_b;
  logic [SWR-1:0] sgf_a;
  logic [SWR-1:0] sgf_b;

  logic           res_valid;
  logic           res_ready;
  logic [EW-1:0]  exp_max;
  logic [SWR-1:0] sgf_major;
  logic [SWR-1:0] sgf_minor;
  logic           sticky;
  logic           swap;

  modport master (
    output op_valid, exp_a, exp_b, sgf_a, sgf_b,
    input  op_ready,
    input  res_valid, exp_max, sgf_major, sgf_minor, sticky, swap,
    output res_ready
  );

  modport slave (
    input  op_valid, exp_a, exp_b, sgf_a, sgf_b,
    output op_ready,
    output res_valid, exp_max, sgf_major, sgf_minor, sticky, swap,
    input  res_ready
  );
endinterface

// File: rtl/sgf_align_unit.sv
// FP add/sub operand alignment: swap by exponent, iterative right shift with sticky.
// Optional ALIGN_EARLY_DONE_EN skips the shift levels when no shift is needed.
module sgf_align_unit #(
  parameter int SWR    = 26,
  parameter int EW     = 8,
  parameter int LEVELS = 5
) (
  input  logic          clk,
  input  logic          rst,
  sgf_align_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    SHIFT,
    DONE
  } state_t;

  localparam int KW = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam logic [EW:0] SWR_E = (EW+1)'(SWR);
  localparam logic [KW-1:0] K_LAST = KW'(LEVELS - 1);

  state_t state;
  state_t next;

  logic [EW-1:0]     ea;
  logic [EW-1:0]     eb;
  logic [SWR-1:0]    sa;
  logic [SWR-1:0]    sb;
  logic [EW-1:0]     emax;
  logic [SWR-1:0]    major;
  logic [SWR-1:0]    minor;
  logic              sticky;
  logic              swap;
  logic              valid;
  logic [LEVELS-1:0] amt;
  logic [KW-1:0]     k;

  logic              accept;
  logic              swap_c;
  logic [EW-1:0]     diff;
  logic              sat;
  logic              skip;
  logic [SWR-1:0]    mn_c;
  logic              last;
  logic [31:0]       lvl;
  logic              lost;

  assign accept = bus.op_valid && bus.op_ready;
  assign swap_c = eb > ea;
  assign diff   = swap_c ? (eb - ea) : (ea - eb);
  assign sat    = {1'b0, diff} >= SWR_E;
  assign mn_c   = swap_c ? sa : sb;
  assign last   = k == K_LAST;
  assign lvl    = 32'd1 << k;
  assign lost   = |(minor & ~({SWR{1'b1}} << lvl));

`ifdef ALIGN_EARLY_DONE_EN
  assign skip = (diff == '0) || sat;
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (accept) next = CMP;
      CMP:   next = SHIFT;
      SHIFT: if (last) next = DONE;
      DONE:  if (bus.res_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea     <= '0;
      eb     <= '0;
      sa     <= '0;
      sb     <= '0;
      emax   <= '0;
      major  <= '0;
      minor  <= '0;
      sticky <= 1'b0;
      swap   <= 1'b0;
      valid  <= 1'b0;
      amt    <= '0;
      k      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            ea <= bus.exp_a;
            eb <= bus.exp_b;
            sa <= bus.sgf_a;
            sb <= bus.sgf_b;
          end
        end
        CMP: begin
          swap   <= swap_c;
          emax   <= swap_c ? eb : ea;
          major  <= swap_c ? sb : sa;
          minor  <= sat ? '0 : mn_c;
          sticky <= sat & (|mn_c);
          amt    <= sat ? '0 : diff[LEVELS-1:0];
          // skipping lands on the last level: one pass-through cycle, no shift
          k      <= skip ? K_LAST : '0;
        end
        SHIFT: begin
          if (amt[k]) begin
            minor  <= minor >> lvl;
            sticky <= sticky | lost;
          end
          k <= last ? '0 : k + 1'b1;
          if (last) valid <= 1'b1;
        end
        DONE: begin
          if (bus.res_ready) valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.op_ready  = (state == IDLE) && !rst;
  assign bus.res_valid = valid;
  assign bus.exp_max   = emax;
  assign bus.sgf_major = major;
  assign bus.sgf_minor = minor;
  assign bus.sticky    = sticky;
  assign bus.swap      = swap;

endmodule

// File: tb/tb_sgf_align_unit.sv
// Scoreboard bench for sgf_align_unit: reference alignment model, latency,
// backpressure and mid-operation reset.
module tb_sgf_align_unit;

  localparam int SWR = 26;
  localparam int EW  = 8;

  typedef struct {
    logic [EW-1:0]  exp_max;
    logic [SWR-1:0] major;
    logic [SWR-1:0] minor;
    logic           sticky;
    logic           swap;
    int             lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  sgf_align_unit_if #(.SWR(SWR), .EW(EW)) bus ();

  sgf_align_unit #(.SWR(SWR), .EW(EW), .LEVELS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [EW-1:0] ea,
                                 input logic [EW-1:0] eb,
                                 input logic [SWR-1:0] sa,
                                 input logic [SWR-1:0] sb);
    exp_t e;
    logic [SWR-1:0] mn;
    logic [SWR-1:0] mask;
    int d;
    e.swap    = eb > ea;
    e.exp_max = e.swap ? eb : ea;
    e.major   = e.swap ? sb : sa;
    mn        = e.swap ? sa : sb;
    d         = e.swap ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
    if (d >= SWR) begin
      e.minor  = '0;
      e.sticky = |mn;
    end else begin
      mask     = (SWR'(1) << d) - SWR'(1);
      e.minor  = mn >> d;
      e.sticky = |(mn & mask);
    end
    e.lat = 6;
`ifdef ALIGN_EARLY_DONE_EN
    if (d == 0 || d >= SWR) e.lat = 2;
`endif
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.op_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 64'(bus.op_ready), 64'd1);
  endtask

  task automatic send(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                      input logic [SWR-1:0] sa, input logic [SWR-1:0] sb);
    wait_ready();
    bus.exp_a    = ea;
    bus.exp_b    = eb;
    bus.sgf_a    = sa;
    bus.sgf_b    = sb;
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk("busy_ready", 64'(bus.op_ready), 64'd0);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".valid"}, 64'(bus.res_valid), 64'd1);
    chk({tag, ".exp_max"}, 64'(bus.exp_max), 64'(e.exp_max));
    chk({tag, ".major"}, 64'(bus.sgf_major), 64'(e.major));
    chk({tag, ".minor"}, 64'(bus.sgf_minor), 64'(e.minor));
    chk({tag, ".sticky"}, 64'(bus.sticky), 64'(e.sticky));
    chk({tag, ".swap"}, 64'(bus.swap), 64'(e.swap));
  endtask

  // bp: cycles of held-off ready with junk pulsed on the operand side
  task automatic run_op(input string tag,
                        input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                        input logic [SWR-1:0] sa, input logic [SWR-1:0] sb,
                        input int bp);
    exp_t e;
    int lat;
    send(ea, eb, sa, sb);
    sb_q.push_back(model(ea, eb, sa, sb));
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
    check_out(tag, e);
    for (int i = 0; i < bp; i++) begin
      bus.op_valid = 1'b1;
      bus.exp_a    = 8'hFF;
      bus.sgf_a    = 26'h3FFFFFF;
      bus.sgf_b    = 26'h2AAAAAA;
      @(posedge clk); #1;
      chk({tag, ".bp_ready"}, 64'(bus.op_ready), 64'd0);
      check_out({tag, ".bp"}, e);
    end
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({tag, ".valid_fall"}, 64'(bus.res_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(bus.op_ready), 64'd1);
  endtask

  initial begin
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    bus.exp_a     = '0;
    bus.exp_b     = '0;
    bus.sgf_a     = '0;
    bus.sgf_b     = '0;
    #1;
    chk("rst.ready", 64'(bus.op_ready), 64'd0);
    chk("rst.valid", 64'(bus.res_valid), 64'd0);
    chk("rst.minor", 64'(bus.sgf_minor), 64'd0);
    chk("rst.exp_max", 64'(bus.exp_max), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst.ready_rel", 64'(bus.op_ready), 64'd1);

    run_op("v1", 8'd10, 8'd7, 26'h2000000, 26'h000000F, 0);
    run_op("v2", 8'd4, 8'd20, 26'h0010000, 26'h3000000, 0);
    run_op("sat1", 8'd200, 8'd0, 26'h0000000, 26'h0000001, 0);
    run_op("sat0", 8'd200, 8'd0, 26'h0000000, 26'h0000000, 0);
    run_op("eq", 8'd50, 8'd50, 26'h0000000, 26'h1234567, 0);
    run_op("d25", 8'd30, 8'd5, 26'h1000000, 26'h3FFFFFF, 0);
    run_op("d26", 8'd5, 8'd31, 26'h2000001, 26'h0000003, 0);
    run_op("bp", 8'd9, 8'd1, 26'h0ABCDEF, 26'h0FF00FF, 3);

    // abort during SHIFT level 2
    send(8'd40, 8'd33, 26'h1111111, 26'h2222222);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.valid", 64'(bus.res_valid), 64'd0);
    chk("abort.minor", 64'(bus.sgf_minor), 64'd0);
    chk("abort.major", 64'(bus.sgf_major), 64'd0);
    chk("abort.sticky", 64'(bus.sticky), 64'd0);
    chk("abort.ready", 64'(bus.op_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (bus.res_valid) seen++;
      end
      chk("abort.no_valid", 64'(seen), 64'd0);
    end
    run_op("post", 8'd12, 8'd15, 26'h00000FF, 26'h1000000, 0);

    for (int i = 0; i < 8; i++) begin
      run_op("rnd", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             26'($urandom), 26'($urandom), 0);
    end
    for (int i = 0; i < 8; i++) begin
      logic [EW-1:0] b;
      b = 8'($urandom_range(0, 225));
      run_op("rnd_near", b + 8'($urandom_range(0, 30)), b,
             26'($urandom), 26'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
